// File: rtl/axis_frame_buffer_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward frame mode, frame dropping and sideband pass-through.
// Space is released only when a beat leaves m_axis, so the read pipeline never adds hidden capacity.
module axis_frame_buffer_fifo #(
  parameter int DEPTH = 4096,
  parameter int DATA_WIDTH = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE = 1'b0,
  parameter int ID_WIDTH = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH = 1,
  parameter bit FRAME_FIFO = 1'b0,
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter bit DROP_BAD_FRAME = 1'b0,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int N_REQ = KEEP_ENABLE ? DEPTH / KEEP_WIDTH : DEPTH;
  localparam int AW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NW = 1 << AW;
  localparam int KO = DATA_WIDTH;
  localparam int IO = KO + KEEP_WIDTH;
  localparam int DO = IO + ID_WIDTH;
  localparam int UO = DO + DEST_WIDTH;
  localparam int WW = UO + USER_WIDTH + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

  if (DROP_WHEN_FULL && !FRAME_FIFO) begin : g_err_dwf
    $error("DROP_WHEN_FULL requires FRAME_FIFO");
  end
  if (DROP_BAD_FRAME && !FRAME_FIFO) begin : g_err_dbf
    $error("DROP_BAD_FRAME requires FRAME_FIFO");
  end
  if (DROP_BAD_FRAME && !USER_ENABLE) begin : g_err_user
    $error("DROP_BAD_FRAME requires USER_ENABLE");
  end

  logic [WW-1:0] mem_q [NW];
  logic [AW:0]   wr_ptr_q, wr_cur_q, rd_ptr_q, rd_addr_q;
  logic          drop_q, good_q, bad_q, ovf_q;
  logic [WW-1:0] rd_dat_q, out_dat_q;
  logic          rd_vld_q, out_vld_q;

  logic          full, full_cur, full_wr, empty;
  logic          in_last, in_bad, s_hs, discard;
  logic          m_hs, out_load, rd_en;
  logic [WW-1:0] s_word;

  // rd_ptr_q frees space on output handshake; rd_addr_q is the RAM fetch address.
  assign full     = (wr_ptr_q ^ rd_ptr_q) == PTR_MSB;
  assign full_cur = (wr_cur_q ^ rd_ptr_q) == PTR_MSB;
  assign full_wr  = (wr_cur_q ^ wr_ptr_q) == PTR_MSB;
  assign empty    = rd_addr_q == wr_ptr_q;

  assign in_last = LAST_ENABLE ? s_axis_tlast : 1'b1;
  assign in_bad  = DROP_BAD_FRAME &&
                   ((s_axis_tuser & USER_BAD_FRAME_MASK) == USER_BAD_FRAME_VALUE);
  assign s_word  = {in_last, s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tkeep, s_axis_tdata};

  assign s_axis_tready = !rst && (FRAME_FIFO ? (DROP_WHEN_FULL || !full_cur || full_wr || drop_q)
                                             : !full);
  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign discard = FRAME_FIFO && (drop_q || full_cur || full_wr);

  assign m_axis_tvalid = out_vld_q && !rst;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign out_load      = rd_vld_q && (!out_vld_q || m_axis_tready);
  assign rd_en         = !empty && (!rd_vld_q || out_load);

  always_ff @(posedge clk) begin
    if (s_hs && !discard) mem_q[wr_cur_q[AW-1:0]] <= s_word;
    if (rd_en) rd_dat_q <= mem_q[rd_addr_q[AW-1:0]];
    if (out_load) out_dat_q <= rd_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_cur_q  <= '0;
      rd_ptr_q  <= '0;
      rd_addr_q <= '0;
      drop_q    <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      ovf_q  <= 1'b0;
      if (s_hs) begin
        if (!FRAME_FIFO) begin
          wr_cur_q <= wr_cur_q + PTR_ONE;
          wr_ptr_q <= wr_cur_q + PTR_ONE;
        end else if (discard) begin
          drop_q <= !in_last;
          if (in_last) begin
            wr_cur_q <= wr_ptr_q;
            ovf_q    <= 1'b1;
          end
        end else if (in_last && in_bad) begin
          wr_cur_q <= wr_ptr_q;
          bad_q    <= 1'b1;
        end else if (in_last) begin
          wr_cur_q <= wr_cur_q + PTR_ONE;
          wr_ptr_q <= wr_cur_q + PTR_ONE;
          good_q   <= 1'b1;
        end else begin
          wr_cur_q <= wr_cur_q + PTR_ONE;
        end
      end
      if (m_hs) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_en) begin
        rd_addr_q <= rd_addr_q + PTR_ONE;
        rd_vld_q  <= 1'b1;
      end else if (out_load) begin
        rd_vld_q <= 1'b0;
      end
      if (out_load) out_vld_q <= 1'b1;
      else if (m_hs) out_vld_q <= 1'b0;
    end
  end

  assign m_axis_tdata = out_dat_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep = KEEP_ENABLE ? out_dat_q[KO +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
  assign m_axis_tid   = ID_ENABLE ? out_dat_q[IO +: ID_WIDTH] : '0;
  assign m_axis_tdest = DEST_ENABLE ? out_dat_q[DO +: DEST_WIDTH] : '0;
  assign m_axis_tuser = USER_ENABLE ? out_dat_q[UO +: USER_WIDTH] : '0;
  assign m_axis_tlast = LAST_ENABLE ? out_dat_q[WW-1] : 1'b1;

  assign status_overflow   = ovf_q;
  assign status_bad_frame  = bad_q;
  assign status_good_frame = good_q;

endmodule

// File: tb/tb_axis_frame_buffer_fifo.sv
// Three FIFO flavours (0: frame+drop-bad, 1: frame+drop-when-full+drop-bad, 2: plain FIFO)
// checked every cycle against a queue-level reference model.
module tb_axis_frame_buffer_fifo;
  localparam int N = 8;

  logic clk, rst;
  logic [2:0][63:0] s_tdata;
  logic [2:0][7:0]  s_tkeep, s_tid, s_tdest;
  logic [2:0]       s_tvalid, s_tlast, s_tuser, m_tready;
  wire  [2:0]       s_tready;
  wire  [2:0][63:0] m_tdata;
  wire  [2:0][7:0]  m_tkeep, m_tid, m_tdest;
  wire  [2:0]       m_tvalid, m_tlast, m_tuser;
  wire  [2:0]       st_ovf, st_bad, st_good;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axis_frame_buffer_fifo #(
      .DEPTH(64), .DATA_WIDTH(64), .ID_ENABLE(1'b1), .DEST_ENABLE(1'b1),
      .FRAME_FIFO(g != 2), .DROP_WHEN_FULL(g == 1), .DROP_BAD_FRAME(g != 2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata[g]), .s_axis_tkeep(s_tkeep[g]), .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]), .s_axis_tlast(s_tlast[g]), .s_axis_tid(s_tid[g]),
      .s_axis_tdest(s_tdest[g]), .s_axis_tuser(s_tuser[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]), .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]), .m_axis_tlast(m_tlast[g]), .m_axis_tid(m_tid[g]),
      .m_axis_tdest(m_tdest[g]), .m_axis_tuser(m_tuser[g]),
      .status_overflow(st_ovf[g]), .status_bad_frame(st_bad[g]), .status_good_frame(st_good[g])
    );
  end

  // Reference model: committed beats awaiting output, and the frame being received.
  logic [89:0] exp_q [3][$];
  logic [89:0] pend  [3][$];
  bit mdrop[3], eg[3], eb[3], eo[3], held[3], prev_v[3];
  int out_cnt[3], good_cnt[3], bad_cnt[3], ovf_cnt[3], rise_cyc[3], good_cyc[3], hs_cyc[3];
  int rdy_mode[3];
  int cyc, checks, errors;

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  task automatic step();
    logic [89:0] b;
    int occ;
    bit rdy;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      occ = exp_q[d].size() + pend[d].size();
      if (rst) rdy = 1'b0;
      else if (d == 2) rdy = exp_q[d].size() < N;
      else rdy = (d == 1) || occ < N || pend[d].size() == N || mdrop[d];
      chk("s_tready", d, s_tready[d], rdy);
      chk("good_frame", d, st_good[d], eg[d]);
      chk("bad_frame", d, st_bad[d], eb[d]);
      chk("overflow", d, st_ovf[d], eo[d]);
      if (held[d] && !rst) chk("m_tvalid_hold", d, m_tvalid[d], 1);
      if (rst) chk("m_tvalid_rst", d, m_tvalid[d], 0);
      else if (m_tvalid[d]) begin
        if (exp_q[d].size() == 0) chk("m_spurious", d, m_tvalid[d], 0);
        else begin
          chk("m_beat", d, {m_tlast[d], m_tuser[d], m_tdest[d], m_tid[d], m_tkeep[d], m_tdata[d]},
              exp_q[d][0]);
          if (m_tready[d]) begin
            void'(exp_q[d].pop_front());
            out_cnt[d]++;
            hs_cyc[d] = cyc;
          end
        end
      end
      if (m_tvalid[d] && !prev_v[d]) rise_cyc[d] = cyc;
      prev_v[d] = m_tvalid[d];
      held[d] = m_tvalid[d] && !m_tready[d];
      if (st_good[d]) begin good_cnt[d]++; good_cyc[d] = cyc; end
      if (st_bad[d]) bad_cnt[d]++;
      if (st_ovf[d]) ovf_cnt[d]++;
      eg[d] = 0; eb[d] = 0; eo[d] = 0;
      if (rst) begin
        exp_q[d].delete(); pend[d].delete(); mdrop[d] = 0;
      end else if (s_tvalid[d] && s_tready[d]) begin
        b = {s_tlast[d], s_tuser[d], s_tdest[d], s_tid[d], s_tkeep[d], s_tdata[d]};
        if (d == 2) exp_q[d].push_back(b);
        else if (mdrop[d] || occ == N || pend[d].size() == N) begin
          mdrop[d] = !s_tlast[d];
          if (s_tlast[d]) begin pend[d].delete(); eo[d] = 1; end
        end else begin
          pend[d].push_back(b);
          if (s_tlast[d]) begin
            if (s_tuser[d]) begin pend[d].delete(); eb[d] = 1; end
            else begin
              while (pend[d].size() > 0) exp_q[d].push_back(pend[d].pop_front());
              eg[d] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic set_beat(input int d, input bit last, input bit bad);
    s_tdata[d] = {$urandom, $urandom};
    s_tkeep[d] = 8'($urandom);
    s_tid[d]   = 8'($urandom);
    s_tdest[d] = 8'($urandom);
    s_tlast[d] = last;
    s_tuser[d] = (d == 2 || !last) ? 1'($urandom) : bad;
    s_tvalid[d] = 1'b1;
  endtask

  task automatic beat(input int d, input bit last, input bit bad);
    int n;
    n = 0;
    set_beat(d, last, bad);
    do begin @(negedge clk); n++; end while (!s_tready[d] && n < 300);
    chk("beat_accept", d, s_tready[d], 1);
    @(posedge clk); #1;
    s_tvalid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input int n, input string name);
    int k;
    k = 0;
    while (out_cnt[d] < n && k < 400) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
    chk(name, d, out_cnt[d], n);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    int base, gb, bb, ob, acc, len, d, k, tot;
    bit bad;
    rst = 1; s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tid = '0; s_tdest = '0;
    s_tlast = '0; s_tuser = '0; m_tready = '1;
    for (int i = 0; i < 3; i++) rdy_mode[i] = 1;
    repeat (3) @(posedge clk);
    fork
      forever begin @(negedge clk); step(); end
      forever begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) m_tready[i] = (rdy_mode[i] == 2) ? 1'($urandom) : (rdy_mode[i] == 1);
      end
    join_none
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tready", i, s_tready[i], 1);
      chk("rst_tvalid", i, m_tvalid[i], 0);
    end

    // Store-and-forward timing and throughput.
    gb = good_cnt[0];
    for (int j = 0; j < 3; j++) beat(0, j == 2, 0);
    wait_out(0, 3, "t1_out");
    chk("t1_good", 0, good_cnt[0] - gb, 1);
    chk("t1_latency", 0, rise_cyc[0] - good_cyc[0], 2);
    chk("t1_span", 0, hs_cyc[0] - rise_cyc[0], 2);

    // Bad frame rolled back, following good frame intact.
    base = out_cnt[0]; gb = good_cnt[0]; bb = bad_cnt[0];
    beat(0, 0, 0); beat(0, 1, 1); beat(0, 1, 0);
    wait_out(0, base + 1, "t3_out");
    chk("t3_bad", 0, bad_cnt[0] - bb, 1);
    chk("t3_good", 0, good_cnt[0] - gb, 1);

    // Oversized frame always dropped; FIFO usable afterwards.
    base = out_cnt[0]; ob = ovf_cnt[0];
    for (int j = 0; j < 9; j++) beat(0, j == 8, 0);
    beat(0, 1, 0);
    wait_out(0, base + 1, "t4_out");
    chk("t4_ovf", 0, ovf_cnt[0] - ob, 1);

    // Reset in the middle of a frame; the tail becomes a new frame.
    beat(0, 0, 0); beat(0, 0, 0);
    rst = 1;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    base = out_cnt[0];
    beat(0, 0, 0); beat(0, 1, 0);
    wait_out(0, base + 2, "t6_out");

    // Drop-when-full: second frame overflows while the first sits unread.
    rdy_mode[1] = 0;
    repeat (2) @(posedge clk); #1;
    for (int j = 0; j < 6; j++) beat(1, j == 5, 0);
    for (int j = 0; j < 4; j++) beat(1, j == 3, 0);
    repeat (3) @(posedge clk);
    chk("t2_ovf", 1, ovf_cnt[1], 1);
    chk("t2_none_out", 1, out_cnt[1], 0);
    rdy_mode[1] = 1;
    wait_out(1, 6, "t2_out");

    // Plain FIFO: exactly N beats absorbed with the sink stalled.
    rdy_mode[2] = 0;
    repeat (2) @(posedge clk); #1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      set_beat(2, 1'($urandom), 0);
      @(negedge clk);
      if (s_tready[2]) acc++;
      @(posedge clk); #1;
    end
    s_tvalid[2] = 0;
    chk("t5_fill", 2, acc, 8);
    rdy_mode[2] = 2;
    for (int i = 0; i < 20; i++) beat(2, 1'($urandom), 0);
    wait_out(2, 28, "t5_out");

    // Randomized frames against the model.
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1);
      rdy_mode[d] = 2;
      len = $urandom_range(1, 10);
      bad = ($urandom_range(0, 4) == 0);
      for (int j = 0; j < len; j++) beat(d, j == len - 1, bad);
    end

    for (int i = 0; i < 3; i++) rdy_mode[i] = 1;
    k = 0;
    tot = 1;
    while (tot != 0 && k < 400) begin
      @(posedge clk);
      tot = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      k++;
    end
    for (int i = 0; i < 3; i++) chk("drain", i, exp_q[i].size() + pend[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
